// File: rtl/arb_pkg.sv
// arb_pkg: AXI-Stream beat types, arbiter state encoding and a reference round-robin helper.
`default_nettype none

package arb_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 3;
  localparam int DEST_WIDTH = 0;
  localparam int USER_WIDTH = 0;
  localparam int MAX_INPUTS = 16;

  // A field of width 0 is absent; it keeps one bit so the struct stays legal, and sources hold it at 0.
  localparam int ID_BITS   = (ID_WIDTH   > 0) ? ID_WIDTH   : 1;
  localparam int DEST_BITS = (DEST_WIDTH > 0) ? DEST_WIDTH : 1;
  localparam int USER_BITS = (USER_WIDTH > 0) ? USER_WIDTH : 1;

  typedef struct packed {
    logic                  tvalid;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [ID_BITS-1:0]    tid;
    logic [DEST_BITS-1:0]  tdest;
    logic [USER_BITS-1:0]  tuser;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // One-hot grant of the first requester after ptr, wrapping modulo n.
  function automatic logic [MAX_INPUTS-1:0] rr_next(input int unsigned ptr,
                                                    input logic [MAX_INPUTS-1:0] req,
                                                    input int unsigned n);
    logic [MAX_INPUTS-1:0] gnt;
    int unsigned           idx;
    gnt = '0;
    for (int unsigned k = 1; k <= MAX_INPUTS; k++) begin
      if (k <= n) begin
        idx = (ptr + k) % n;
        if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_select.sv
// rr_priority_select: combinational round-robin pick; rotate req past ptr, take lowest set bit, rotate back.
`default_nettype none

module rr_priority_select #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   rot_req;
  logic [N-1:0]   rot_gnt;
  int unsigned    start;

  always_comb begin
    start   = 32'(ptr) + 32'd1;
    req_dbl = {req, req};
    rot_req = req_dbl[start +: N];
    rot_gnt = rot_req & (~rot_req + N'(1));
    gnt_dbl = {{N{1'b0}}, rot_gnt} << start;
    gnt     = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

endmodule

`default_nettype wire

// File: rtl/axis_packet_rr_arbiter.sv
// axis_packet_rr_arbiter: packet-atomic round-robin mux of N_INPUTS AXI-Stream inputs onto one output.
// Define ARB_PMU_EN to add per-input completed-packet counters (pkt_cnt_o, CNT_WIDTH bits, wrapping).
`default_nettype none

module axis_packet_rr_arbiter
  import arb_pkg::*;
#(
  parameter int N_INPUTS = 5
`ifdef ARB_PMU_EN
  , parameter int CNT_WIDTH = 32
`endif
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  axis_mosi_t [N_INPUTS-1:0]    in_mosi_i,
  output axis_miso_t [N_INPUTS-1:0]    in_miso_o,
  output axis_mosi_t                   out_mosi_o,
  input  axis_miso_t                   out_miso_i,
  output logic [N_INPUTS-1:0]          grant_o,
  output logic                         busy_o
`ifdef ARB_PMU_EN
  , output logic [N_INPUTS-1:0][CNT_WIDTH-1:0] pkt_cnt_o
`endif
);

  localparam int PW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  arb_state_e          state, state_nxt;
  logic [N_INPUTS-1:0] grant_nxt;
  logic [N_INPUTS-1:0] req;
  logic [N_INPUTS-1:0] sel;
  logic [PW-1:0]       ptr, ptr_nxt;
  logic [PW-1:0]       gidx;
  logic                last_hs;

  always_comb begin
    for (int i = 0; i < N_INPUTS; i++) req[i] = in_mosi_i[i].tvalid;
  end

  rr_priority_select #(.N(N_INPUTS), .PW(PW)) u_sel (
    .req (req),
    .ptr (ptr),
    .gnt (sel)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (grant_o[i]) gidx = PW'(i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state   <= IDLE;
      grant_o <= '0;
      ptr     <= PW'(N_INPUTS - 1);
    end else begin
      state   <= state_nxt;
      grant_o <= grant_nxt;
      ptr     <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant_o;
    ptr_nxt    = ptr;
    out_mosi_o = '0;
    in_miso_o  = '0;
    last_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = sel;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        // Grant is held until the TLAST handshake; a withdrawn TVALID just shows as a bubble.
        out_mosi_o              = in_mosi_i[gidx];
        in_miso_o[gidx].tready  = out_miso_i.tready;
        last_hs = in_mosi_i[gidx].tvalid && in_mosi_i[gidx].tlast && out_miso_i.tready;
        if (last_hs) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          ptr_nxt   = gidx;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == LOCKED);

`ifdef ARB_PMU_EN
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pkt_cnt_o <= '0;
    end else if (last_hs) begin
      pkt_cnt_o[gidx] <= pkt_cnt_o[gidx] + CNT_WIDTH'(1);
    end
  end
`else
  // Counters are not built in this configuration.
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_packet_rr_arbiter.sv
// tb_axis_packet_rr_arbiter: table-driven grant checks plus scoreboarded packet sequences.
`default_nettype none

module tb_axis_packet_rr_arbiter;
  import arb_pkg::*;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  axis_mosi_t [N-1:0]   in_mosi;
  axis_miso_t [N-1:0]   in_miso;
  axis_mosi_t           out_mosi;
  axis_miso_t           out_miso;
  logic [N-1:0]         grant;
  logic                 busy;
`ifdef ARB_PMU_EN
  logic [N-1:0][31:0]   pkt_cnt;
  axis_miso_t [N-1:0]   in_miso_w;
  axis_mosi_t           out_mosi_w;
  logic [N-1:0]         grant_w;
  logic                 busy_w;
  logic [N-1:0][2:0]    pkt_cnt_w;
`endif

  axis_packet_rr_arbiter #(
    .N_INPUTS (N)
`ifdef ARB_PMU_EN
    , .CNT_WIDTH (32)
`endif
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_mosi_i  (in_mosi),
    .in_miso_o  (in_miso),
    .out_mosi_o (out_mosi),
    .out_miso_i (out_miso),
    .grant_o    (grant),
    .busy_o     (busy)
`ifdef ARB_PMU_EN
    , .pkt_cnt_o (pkt_cnt)
`endif
  );

`ifdef ARB_PMU_EN
  axis_packet_rr_arbiter #(.N_INPUTS(N), .CNT_WIDTH(3)) dut_w (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_mosi_i  (in_mosi),
    .in_miso_o  (in_miso_w),
    .out_mosi_o (out_mosi_w),
    .out_miso_i (out_miso),
    .grant_o    (grant_w),
    .busy_o     (busy_w),
    .pkt_cnt_o  (pkt_cnt_w)
  );
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [2:0]  src;
  } beat_t;

  typedef struct {
    int         seed;
    logic [4:0] mask;
    logic [4:0] exp_grant;
  } vec_t;

  beat_t      src_q[N][$];
  beat_t      exp_q[$];
  int         hs_cyc[$];
  vec_t       vecs[12];
  logic [N-1:0] pause;
  logic [3:0] rdy_pat;
  int         rdy_ph;
  int         cyc;
  int         checks;
  int         failures;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int src, input int n, input int id);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = {8'(src), 8'(id), 16'(k)};
      b.last = (k == n - 1);
      b.src  = 3'(src);
      src_q[src].push_back(b);
    end
  endtask

  task automatic exp_pkt(input int src, input int n, input int id, input int cnt);
    beat_t b;
    for (int k = 0; k < cnt; k++) begin
      b.data = {8'(src), 8'(id), 16'(k)};
      b.last = (k == n - 1);
      b.src  = 3'(src);
      exp_q.push_back(b);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_mosi[i] = '0;
      if (src_q[i].size() > 0 && !pause[i]) begin
        in_mosi[i].tvalid = 1'b1;
        in_mosi[i].tdata  = src_q[i][0].data;
        in_mosi[i].tlast  = src_q[i][0].last;
        in_mosi[i].tid    = src_q[i][0].src;
      end
    end
    out_miso.tready = rdy_pat[2'(rdy_ph % 4)];
  endtask

  task automatic monitor();
    logic  leak;
    logic  popped;
    beat_t e;
    leak = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_miso[i].tready && !grant[i]) leak = 1'b1;
    end
    check("tready_leak", 64'(leak), 64'd0);
    if (out_mosi.tvalid && out_miso.tready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_beat: got data %0h expected no beat", out_mosi.tdata);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", 64'(out_mosi.tdata), 64'(e.data));
        check("beat_last", 64'(out_mosi.tlast), 64'(e.last));
        check("beat_tid", 64'(out_mosi.tid), 64'(e.src));
      end
      popped = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (in_miso[i].tready && in_mosi[i].tvalid) begin
          void'(src_q[i].pop_front());
          popped = 1'b1;
        end
      end
      check("beat_source", 64'(popped), 64'd1);
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    rdy_ph++;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > target && n < budget) begin
      step();
      n++;
    end
    if (exp_q.size() > target) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d beats pending expected %0d", exp_q.size(), target);
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
    pause   = '0;
    rdy_pat = 4'b1111;
    rdy_ph  = 0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    pause    = '0;
    rdy_pat  = 4'b1111;
    rdy_ph   = 0;
    in_mosi  = '0;
    out_miso = '0;

    // seed = input that completes a packet first (sets ptr); -1 leaves ptr at its reset value 4
    vecs[0]  = '{-1, 5'b01001, 5'b00001};
    vecs[1]  = '{-1, 5'b11110, 5'b00010};
    vecs[2]  = '{-1, 5'b10000, 5'b10000};
    vecs[3]  = '{ 0, 5'b00011, 5'b00010};
    vecs[4]  = '{ 1, 5'b00011, 5'b00001};
    vecs[5]  = '{ 2, 5'b10001, 5'b10000};
    vecs[6]  = '{ 3, 5'b00101, 5'b00001};
    vecs[7]  = '{ 4, 5'b11111, 5'b00001};
    vecs[8]  = '{ 4, 5'b10100, 5'b00100};
    vecs[9]  = '{ 2, 5'b00100, 5'b00100};
    vecs[10] = '{ 3, 5'b01000, 5'b01000};
    vecs[11] = '{ 1, 5'b10101, 5'b00100};

    do_reset();
    drive();
    @(negedge clk);
    check("reset_grant", 64'(grant), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_tvalid", 64'(out_mosi.tvalid), 64'd0);
    check("reset_in_tready", 64'(in_miso), 64'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 12; v++) begin
      do_reset();
      if (vecs[v].seed >= 0) begin
        add_pkt(vecs[v].seed, 1, 99);
        exp_pkt(vecs[v].seed, 1, 99, 1);
        run_until(0, 20);
      end
      for (int i = 0; i < N; i++) begin
        if (vecs[v].mask[i]) add_pkt(i, 1, v);
      end
      drive();
      @(posedge clk);
      #1;
      drive();
      @(negedge clk);
      check($sformatf("table_grant_%0d", v), 64'(grant), 64'(vecs[v].exp_grant));
      check($sformatf("table_busy_%0d", v), 64'(busy), 64'd1);
      @(posedge clk);
      #1;
    end

    // Fairness: three inputs with two 3-beat packets each
    do_reset();
    for (int p = 0; p < 2; p++) begin
      add_pkt(1, 3, p);
      add_pkt(2, 3, p);
      add_pkt(4, 3, p);
    end
    for (int p = 0; p < 2; p++) begin
      exp_pkt(1, 3, p, 3);
      exp_pkt(2, 3, p, 3);
      exp_pkt(4, 3, p, 3);
    end
    run_until(0, 100);

    // Backpressure 1010 on a 4-beat packet from input 2, competitors arrive after the grant
    do_reset();
    rdy_pat = 4'b0101;
    add_pkt(2, 4, 0);
    exp_pkt(2, 4, 0, 4);
    step();
    add_pkt(0, 2, 1);
    add_pkt(4, 2, 2);
    exp_pkt(4, 2, 2, 2);
    exp_pkt(0, 2, 1, 2);
    run_until(0, 100);
    rdy_pat = 4'b1111;

    // Bubble: input 3 pauses two cycles mid-packet while input 0 waits
    do_reset();
    add_pkt(3, 4, 0);
    exp_pkt(3, 4, 0, 4);
    step();
    add_pkt(0, 2, 1);
    exp_pkt(0, 2, 1, 2);
    run_until(5, 20);
    pause[3] = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("bubble_grant", 64'(grant), 64'b01000);
      check("bubble_out_tvalid", 64'(out_mosi.tvalid), 64'd0);
    end
    pause[3] = 1'b0;
    run_until(0, 40);

    // Back-to-back single-beat packets on inputs 0 and 1
    do_reset();
    hs_cyc.delete();
    add_pkt(0, 1, 0);
    add_pkt(1, 1, 1);
    exp_pkt(0, 1, 0, 1);
    exp_pkt(1, 1, 1, 1);
    run_until(0, 20);
    check("b2b_handshakes", 64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() == 2) check("b2b_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd2);

    // Reset in the middle of a packet, then packet counting on input 1
    do_reset();
    add_pkt(1, 4, 0);
    exp_pkt(1, 4, 0, 2);
    run_until(0, 20);
    check("midpkt_busy_before", 64'(busy), 64'd1);
    do_reset();
    drive();
    @(negedge clk);
    check("midpkt_grant_after", 64'(grant), 64'd0);
    check("midpkt_busy_after", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    for (int p = 0; p < 9; p++) begin
      add_pkt(1, 1, p);
      exp_pkt(1, 1, p, 1);
      run_until(0, 20);
`ifdef ARB_PMU_EN
      if (p == 4) check("pmu_cnt5", 64'(pkt_cnt[1]), 64'd5);
`endif
    end
`ifdef ARB_PMU_EN
    check("pmu_cnt9", 64'(pkt_cnt[1]), 64'd9);
    check("pmu_cnt_other", 64'(pkt_cnt[0]), 64'd0);
    check("pmu_wrap", 64'(pkt_cnt_w[1]), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
